// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: FSM states, op codes, default width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CALC   = 2'b01,
      FINISH = 2'b10
   } mdu_state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate: magnitude of a signed operand, or sign fix-up of a result.
// Latency: combinational.
// Backpressure: none.
module mdu_abs_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   // The most negative value maps to itself, which reads correctly as an unsigned magnitude.
   assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring on magnitudes) producing HI/LO.
// Latency: done WIDTH+1 edges after the accepting edge; 1 edge for divide-by-zero.
// Backpressure: start is honoured only in IDLE with done low; otherwise it is dropped.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Accumulator layout: {P_hi (WIDTH+1 bits), P_lo (WIDTH bits), q-1}.
   // P_hi carries one guard bit so Booth never overflows on the most negative multiplicand.
   // For DIV, P_hi[WIDTH-1:0] holds the partial remainder and P_lo the dividend/quotient.
   localparam int ACC_W = 2 * WIDTH + 2;

   mdu_state_e         state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_q, op_d;
   logic               an_q, an_d;
   logic               bn_q, bn_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [WIDTH:0]     ph;
   logic [WIDTH-1:0]   pl;
   logic               qm1;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
   logic [WIDTH:0]     m_ext, booth_sum;
   logic [ACC_W-1:0]   booth_nxt;
   logic [WIDTH:0]     trial, rem_nxt;
   logic               q_bit;
   logic [ACC_W-1:0]   div_nxt;

   assign ph  = acc_q[ACC_W-1 -: WIDTH+1];
   assign pl  = acc_q[WIDTH:1];
   assign qm1 = acc_q[0];

   mdu_abs_neg #(.W(WIDTH)) u_abs_a (.val_i(a),               .neg_i(a[WIDTH-1]), .res_o(a_mag));
   mdu_abs_neg #(.W(WIDTH)) u_abs_b (.val_i(b),               .neg_i(b[WIDTH-1]), .res_o(b_mag));
   mdu_abs_neg #(.W(WIDTH)) u_fix_q (.val_i(pl),              .neg_i(an_q ^ bn_q), .res_o(quo_fix));
   mdu_abs_neg #(.W(WIDTH)) u_fix_r (.val_i(ph[WIDTH-1:0]),   .neg_i(an_q),        .res_o(rem_fix));

   // Booth step: add/subtract sign-extended multiplicand per {q0, q-1}, then arithmetic shift right.
   always_comb begin
      m_ext = {mcand_q[WIDTH-1], mcand_q};
      case ({pl[0], qm1})
         2'b01:   booth_sum = ph + m_ext;
         2'b10:   booth_sum = ph - m_ext;
         default: booth_sum = ph;
      endcase
      booth_nxt = {booth_sum[WIDTH], booth_sum, pl};
   end

   // Restoring step: shift next dividend bit into the remainder, subtract divisor if it fits.
   always_comb begin
      trial   = {ph[WIDTH-1:0], pl[WIDTH-1]};
      q_bit   = (trial >= {1'b0, mcand_q});
      rem_nxt = q_bit ? (trial - {1'b0, mcand_q}) : trial;
      div_nxt = {rem_nxt, pl[WIDTH-2:0], q_bit, 1'b0};
   end

   // Next-state and datapath control for IDLE -> CALC -> FINISH.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      an_d    = an_q;
      bn_d    = bn_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            // done_q high means we are in the pulse cycle; starts there are dropped.
            if (start && !done_q) begin
               op_d   = op;
               an_d   = a[WIDTH-1];
               bn_d   = b[WIDTH-1];
               dz_d   = 1'b0;
               busy_d = 1'b1;
               cnt_d  = '0;
               if (op == OP_DIV) begin
                  mcand_d = b_mag;
                  acc_d   = {{(WIDTH+1){1'b0}}, a_mag, 1'b0};
                  state_d = (b == '0) ? FINISH : CALC;
               end else begin
                  mcand_d = a;
                  acc_d   = {{(WIDTH+1){1'b0}}, b, 1'b0};
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = (op_q == OP_DIV) ? div_nxt : booth_nxt;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = FINISH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
            // A zero divisor magnitude only arises from b == 0; results are left untouched then.
            if (op_q == OP_DIV && mcand_q == '0) begin
               dz_d = 1'b1;
            end else if (op_q == OP_DIV) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = ph[WIDTH-1:0];
               lo_d = pl;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         op_q    <= OP_MULT;
         an_q    <= 1'b0;
         bn_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         an_q    <= an_d;
         bn_q    <= bn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, random ops against a 64-bit model, and corner sequences.
// Latency: expects done 33 edges after the accepting edge (1 edge for divide-by-zero).
// Backpressure: checks that start is dropped while busy or during the done pulse.
module tb_mult_div_unit;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        op;
   logic [31:0] a, b;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } vec_t;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse pops the oldest expected result.
   always @(negedge clk) begin
      if (reset_n && done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            mon_e = sb.pop_front();
            check("hi", {32'd0, hi}, {32'd0, mon_e.hi});
            check("lo", {32'd0, lo}, {32'd0, mon_e.lo});
            check("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
         end
      end
   end

   task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input logic ed);
      exp_t e;
      e.hi = eh;
      e.lo = el;
      e.dz = ed;
      sb.push_back(e);
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int   n;
      logic busy_ok;
      @(negedge clk);
      start = 1'b1;
      op    = v.op;
      a     = v.a;
      b     = v.b;
      push_exp(v.hi, v.lo, v.dz);
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      n       = 0;
      busy_ok = 1'b1;
      while (!done && n < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(v.lat));
      check({tag, "_busy_held"}, {63'd0, busy_ok}, 64'd1);
      check({tag, "_busy_low_at_done"}, {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
   endtask

   vec_t        vecs[11];
   vec_t        rv;
   longint      sa, sbv, prod, quo, rem;
   int          d0, n;

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 1'b0;
      a       = '0;
      b       = '0;

      vecs[0]  = '{1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
      vecs[1]  = '{1'b1, 32'd5,          32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1};
      vecs[2]  = '{1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
      vecs[3]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
      vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
      vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
      vecs[6]  = '{1'b1, 32'd100,        32'd7,        32'd2,        32'd14,       1'b0, 33};
      vecs[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
      vecs[8]  = '{1'b0, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
      vecs[9]  = '{1'b0, 32'h12345678,   32'd0,        32'd0,        32'd0,        1'b0, 33};
      vecs[10] = '{1'b1, 32'd3,          32'd0,        32'd0,        32'd0,        1'b1, 1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_div_zero", {63'd0, div_zero}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // Random signed operations against a 64-bit reference.
      for (int i = 0; i < 16; i++) begin
         rv.op = 1'($urandom_range(0, 1));
         rv.a  = $urandom;
         rv.b  = $urandom;
         if (i % 4 == 0) rv.b = 32'($urandom_range(1, 9));
         if (rv.b == 32'd0) rv.b = 32'd1;
         sa  = longint'($signed(rv.a));
         sbv = longint'($signed(rv.b));
         if (rv.op) begin
            quo   = sa / sbv;
            rem   = sa % sbv;
            rv.hi = rem[31:0];
            rv.lo = quo[31:0];
         end else begin
            prod  = sa * sbv;
            rv.hi = prod[63:32];
            rv.lo = prod[31:0];
         end
         rv.dz  = 1'b0;
         rv.lat = 33;
         run_op(rv, $sformatf("rnd%0d", i));
      end

      // start re-pulsed mid-CALC and through the done cycle must be dropped.
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
      push_exp(32'd0, 32'd42, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1; op = 1'b1; a = 32'd1; b = 32'd0;
      n = 10;
      while (!done && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("repulse_latency", 64'(n), 64'd33);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("repulse_done_fell", {63'd0, done}, 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check("repulse_idle_busy", {63'd0, busy}, 64'd0);
      check("repulse_single_done", 64'(done_cnt - d0), 64'd1);

      // Synchronous reset during CALC aborts the operation.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_hi", {32'd0, hi}, 64'd0);
      check("abort_lo", {32'd0, lo}, 64'd0);
      d0 = done_cnt;
      repeat (40) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      rv = '{1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33};
      run_op(rv, "post_reset");

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
